// File: rtl/descriptor_fetcher.sv
// Avalon-MM master that walks a linked chain of 4-word DMA descriptors and hands each to the DMA engine.
// Optional completion-status writeback to the descriptor's ctrl word: define DESC_WRITEBACK_EN.
//
// state    | meaning
// IDLE     | waiting for start
// FETCH    | four back-to-back reads of B..B+3, captures trail by one cycle
// CHECK    | inspect own bit of the captured ctrl word
// PRESENT  | desc_valid high, waiting for desc_ready
// WB_WAIT  | wb_ready high, waiting for engine status (writeback build only)
// WB_WRITE | single write of status + cleared own to B+3 (writeback build only)
// FINISH   | one-cycle done pulse
module descriptor_fetcher #(
   parameter int ADDR_W = 14,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] head_ptr,
   output logic              busy,
   output logic              done,
   output logic              halted,
   output logic [CNT_W-1:0]  desc_count,
   output logic [ADDR_W-1:0] m_address,
   output logic              m_chipselect,
   output logic              m_write,
   output logic [3:0]        m_byteenable,
   output logic [31:0]       m_writedata,
   output logic              m_clken,
   input  logic [31:0]       m_readdata,
   output logic              desc_valid,
   input  logic              desc_ready,
   output logic [31:0]       desc_src,
   output logic [31:0]       desc_dst,
   output logic [31:0]       desc_len,
   output logic [15:0]       desc_ctrl,
   input  logic              wb_valid,
   input  logic [15:0]       wb_status,
   output logic              wb_ready
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CHECK,
      PRESENT,
`ifdef DESC_WRITEBACK_EN
      WB_WAIT,
      WB_WRITE,
`endif
      FINISH
   } state_t;

   state_t            state;
   logic [2:0]        beat;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] next_ptr;
   logic              eol;
   logic              own;

   assign next_ptr     = ADDR_W'(desc_ctrl[13:0]);
   assign eol          = desc_ctrl[14];
   assign own          = desc_ctrl[15];
   assign m_clken      = 1'b1;
   assign m_byteenable = m_chipselect ? 4'hF : 4'h0;

`ifndef DESC_WRITEBACK_EN
   logic unused_wb;
   assign unused_wb   = ^{wb_valid, wb_status, base};
   assign m_write     = 1'b0;
   assign m_writedata = 32'h0;
   assign wb_ready    = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         beat         <= '0;
         base         <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         halted       <= 1'b0;
         desc_count   <= '0;
         m_address    <= '0;
         m_chipselect <= 1'b0;
         desc_valid   <= 1'b0;
         desc_src     <= '0;
         desc_dst     <= '0;
         desc_len     <= '0;
         desc_ctrl    <= '0;
`ifdef DESC_WRITEBACK_EN
         m_write      <= 1'b0;
         m_writedata  <= '0;
         wb_ready     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         // FINISH is already ending the walk, so abort there adds no second done pulse
         if (abort && state != IDLE && state != FINISH) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b1;
            m_chipselect <= 1'b0;
            desc_valid   <= 1'b0;
`ifdef DESC_WRITEBACK_EN
            m_write      <= 1'b0;
            wb_ready     <= 1'b0;
`endif
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     base         <= head_ptr;
                     desc_count   <= '0;
                     halted       <= 1'b0;
                     busy         <= 1'b1;
                     beat         <= '0;
                     m_address    <= head_ptr;
                     m_chipselect <= 1'b1;
                     state        <= FETCH;
                  end
               end
               FETCH: begin
                  beat <= beat + 3'd1;
                  if (beat < 3'd3) m_address <= m_address + ADDR_W'(1);
                  else             m_chipselect <= 1'b0;
                  // read data for the word issued one beat earlier
                  case (beat)
                     3'd1:    desc_src <= m_readdata;
                     3'd2:    desc_dst <= m_readdata;
                     3'd3:    desc_len <= m_readdata;
                     3'd4: begin
                        desc_ctrl <= m_readdata[15:0];
                        state     <= CHECK;
                     end
                     default: ;
                  endcase
               end
               CHECK: begin
                  if (!own) begin
                     halted <= 1'b1;
                     done   <= 1'b1;
                     state  <= FINISH;
                  end else begin
                     desc_valid <= 1'b1;
                     state      <= PRESENT;
                  end
               end
               PRESENT: begin
                  if (desc_ready) begin
                     desc_valid <= 1'b0;
                     desc_count <= desc_count + CNT_W'(1);
`ifdef DESC_WRITEBACK_EN
                     wb_ready   <= 1'b1;
                     state      <= WB_WAIT;
`else
                     if (eol) begin
                        done  <= 1'b1;
                        state <= FINISH;
                     end else begin
                        base         <= next_ptr;
                        m_address    <= next_ptr;
                        m_chipselect <= 1'b1;
                        beat         <= '0;
                        state        <= FETCH;
                     end
`endif
                  end
               end
`ifdef DESC_WRITEBACK_EN
               WB_WAIT: begin
                  if (wb_valid) begin
                     wb_ready     <= 1'b0;
                     m_chipselect <= 1'b1;
                     m_write      <= 1'b1;
                     m_address    <= base + ADDR_W'(3);
                     m_writedata  <= {wb_status, desc_ctrl & 16'h7FFF};
                     state        <= WB_WRITE;
                  end
               end
               WB_WRITE: begin
                  m_write <= 1'b0;
                  if (eol) begin
                     m_chipselect <= 1'b0;
                     done         <= 1'b1;
                     state        <= FINISH;
                  end else begin
                     base         <= next_ptr;
                     m_address    <= next_ptr;
                     beat         <= '0;
                     state        <= FETCH;
                  end
               end
`endif
               FINISH: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
